// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: sync, active-video, coordinates, lookahead and frame strobes.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [9:0] pre_x;
  logic [9:0] pre_y;
  logic       frame_start;
  logic       vblank_start;
  logic [7:0] frame_count;

  modport master (
    output hsync, vsync, video_active, pix_x, pix_y, pre_x, pre_y,
           frame_start, vblank_start, frame_count
  );

  modport slave (
    input  hsync, vsync, video_active, pix_x, pix_y, pre_x, pre_y,
           frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, a lookahead
// counter running LOOKAHEAD clocks ahead, registered sync/active outputs and
// frame-level strobes. Every output is registered and aligned to pix_x/pix_y.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned LOOKAHEAD = 2
) (
  input  logic              clk,
  input  logic              boot_reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] PRE_X0   = 10'(LOOKAHEAD);

  logic [9:0] px, py, px_n, py_n;
  logic [9:0] qx, qy, qx_n, qy_n;
  logic       wrap;
  logic       hs_q, vs_q, act_q, fs_q, vbs_q;
  logic [7:0] fc_q;

  // Next position of the displayed-pixel counter.
  always_comb begin
    px_n = px + 10'd1;
    py_n = py;
    if (px == H_LAST) begin
      px_n = '0;
      py_n = (py == V_LAST) ? '0 : py + 10'd1;
    end
  end

  // Next position of the lookahead counter; same wrap rules, offset at reset.
  always_comb begin
    qx_n = qx + 10'd1;
    qy_n = qy;
    if (qx == H_LAST) begin
      qx_n = '0;
      qy_n = (qy == V_LAST) ? '0 : qy + 10'd1;
    end
  end

  // Last pixel of the frame: the following edge lands on (0,0).
  always_comb begin
    wrap = (px == H_LAST) && (py == V_LAST);
  end

  // Counters and all registered outputs; decodes use the next counter value
  // so each flag lines up with the coordinate it describes.
  always_ff @(posedge clk) begin
    if (boot_reset) begin
      px    <= '0;
      py    <= '0;
      qx    <= PRE_X0;
      qy    <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      act_q <= 1'b1;
      fs_q  <= 1'b0;
      vbs_q <= 1'b0;
      fc_q  <= '0;
    end else begin
      px    <= px_n;
      py    <= py_n;
      qx    <= qx_n;
      qy    <= qy_n;
      hs_q  <= (px_n >= HS_FIRST && px_n <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vs_q  <= (py_n >= VS_FIRST && py_n <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      act_q <= (px_n < H_ACT) && (py_n < V_ACT);
      fs_q  <= wrap;
      vbs_q <= (px_n == '0) && (py_n == V_ACT);
      if (wrap) begin
        fc_q <= fc_q + 8'd1;
      end
    end
  end

  assign vga.pix_x        = px;
  assign vga.pix_y        = py;
  assign vga.pre_x        = qx;
  assign vga.pre_y        = qy;
  assign vga.hsync        = hs_q;
  assign vga.vsync        = vs_q;
  assign vga.video_active = act_q;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vbs_q;
  assign vga.frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance (640x480 line timing and
// lookahead) and one reduced-size instance (16x11 raster) for frame-level
// behaviour, frame_count wrap and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if vb ();
  vga_timing_gen_if vs ();

  vga_timing_gen dut_big (
    .clk        (clk),
    .boot_reset (rst_b),
    .vga        (vb.master)
  );

  vga_timing_gen #(
    .H_ACTIVE  (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (3),
    .V_ACTIVE  (6),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (2),
    .SYNC_POL  (1'b0),
    .LOOKAHEAD (2)
  ) dut_small (
    .clk        (clk),
    .boot_reset (rst_s),
    .vga        (vs.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Clocks elapsed since the last reset edge, per instance.
  longint t_b = 0;
  longint t_s = 0;
  bit     val_b = 1'b0;
  bit     val_s = 1'b0;

  always @(posedge clk) begin
    if (rst_b) begin t_b <= 0; val_b <= 1'b1; end
    else t_b <= t_b + 1;
    if (rst_s) begin t_s <= 0; val_s <= 1'b1; end
    else t_s <= t_s + 1;
  end

  // Expected outputs from the raster's linear position t (active-low sync).
  function automatic logic [52:0] model(input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf,
                                        input int vsn, input int vbp, input int la,
                                        input longint t);
    longint ht, vt, fr, pos, x, y, pp, qx, qy, fc;
    logic hs_e, vs_e, act_e, fs_e, vbs_e;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vsn + vbp;
    fr  = ht * vt;
    pos = t % fr;
    x   = pos % ht;
    y   = pos / ht;
    pp  = (pos + la) % fr;
    qx  = pp % ht;
    qy  = pp / ht;
    hs_e  = !(x >= ha + hf && x < ha + hf + hs);
    vs_e  = !(y >= va + vf && y < va + vf + vsn);
    act_e = (x < ha) && (y < va);
    fs_e  = (t > 0) && (pos == 0);
    vbs_e = (pos == va * ht);
    fc    = (t / fr) % 256;
    return {hs_e, vs_e, act_e, 10'(x), 10'(y), 10'(qx), 10'(qy), fs_e, vbs_e, 8'(fc)};
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [52:0] act, exp;
    if (val_b) begin
      act = {vb.hsync, vb.vsync, vb.video_active, vb.pix_x, vb.pix_y, vb.pre_x,
             vb.pre_y, vb.frame_start, vb.vblank_start, vb.frame_count};
      exp = model(640, 16, 96, 48, 480, 10, 2, 33, 2, t_b);
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL big_model t=%0d: got %h expected %h", t_b, act, exp);
      end
    end
    if (val_s) begin
      act = {vs.hsync, vs.vsync, vs.video_active, vs.pix_x, vs.pix_y, vs.pre_x,
             vs.pre_y, vs.frame_start, vs.vblank_start, vs.frame_count};
      exp = model(8, 2, 3, 3, 6, 1, 2, 2, 2, t_s);
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL small_model t=%0d: got %h expected %h", t_s, act, exp);
      end
    end
    if (n_bad >= 40) finish_run();
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    // Reset held for three cycles: outputs frozen at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_pix_x", int'(vb.pix_x), 0);
      chk("rst_pix_y", int'(vb.pix_y), 0);
      chk("rst_pre_x", int'(vb.pre_x), 2);
      chk("rst_pre_y", int'(vb.pre_y), 0);
      chk("rst_hsync", int'(vb.hsync), 1);
      chk("rst_vsync", int'(vb.vsync), 1);
      chk("rst_active", int'(vb.video_active), 1);
      chk("rst_fcount", int'(vb.frame_count), 0);
      chk("rst_fstart", int'(vb.frame_start), 0);
    end
    rst_b = 1'b0;
    rst_s = 1'b0;

    for (int c = 1; c <= 45290; c++) begin
      @(negedge clk);
      // Full-size line timing and lookahead.
      case (c)
        639:  chk("big_active_639", int'(vb.video_active), 1);
        640:  begin
                chk("big_active_640", int'(vb.video_active), 0);
                chk("big_x_640", int'(vb.pix_x), 640);
              end
        655:  chk("big_hsync_655", int'(vb.hsync), 1);
        656:  chk("big_hsync_656", int'(vb.hsync), 0);
        751:  chk("big_hsync_751", int'(vb.hsync), 0);
        752:  chk("big_hsync_752", int'(vb.hsync), 1);
        799:  begin
                chk("big_x_799", int'(vb.pix_x), 799);
                chk("big_y_799", int'(vb.pix_y), 0);
              end
        800:  begin
                chk("big_x_wrap", int'(vb.pix_x), 0);
                chk("big_y_wrap", int'(vb.pix_y), 1);
              end
        8799: begin
                chk("big_x_l10", int'(vb.pix_x), 799);
                chk("big_y_l10", int'(vb.pix_y), 10);
                chk("big_pre_x_l10", int'(vb.pre_x), 1);
                chk("big_pre_y_l10", int'(vb.pre_y), 11);
              end
        default: ;
      endcase
      // Reduced raster: 16 clocks/line, 11 lines, 176 clocks/frame.
      case (c)
        95:  chk("sm_vblank_95", int'(vs.vblank_start), 0);
        96:  begin
               chk("sm_vblank_96", int'(vs.vblank_start), 1);
               chk("sm_y_96", int'(vs.pix_y), 6);
             end
        111: chk("sm_vsync_111", int'(vs.vsync), 1);
        112: chk("sm_vsync_112", int'(vs.vsync), 0);
        143: chk("sm_vsync_143", int'(vs.vsync), 0);
        144: chk("sm_vsync_144", int'(vs.vsync), 1);
        174: begin
               chk("sm_pre_x_end", int'(vs.pre_x), 0);
               chk("sm_pre_y_end", int'(vs.pre_y), 0);
             end
        175: begin
               chk("sm_fstart_175", int'(vs.frame_start), 0);
               chk("sm_fcount_175", int'(vs.frame_count), 0);
             end
        176: begin
               chk("sm_fstart_176", int'(vs.frame_start), 1);
               chk("sm_fcount_176", int'(vs.frame_count), 1);
               chk("sm_x_176", int'(vs.pix_x), 0);
             end
        177: chk("sm_fstart_177", int'(vs.frame_start), 0);
        44880: chk("sm_fcount_255", int'(vs.frame_count), 255);
        45055: chk("sm_fcount_pre_wrap", int'(vs.frame_count), 255);
        45056: begin
                 chk("sm_fcount_wrap", int'(vs.frame_count), 0);
                 chk("sm_fstart_wrap", int'(vs.frame_start), 1);
               end
        45109: begin
                 chk("sm_mid_x", int'(vs.pix_x), 5);
                 chk("sm_mid_y", int'(vs.pix_y), 3);
                 rst_s = 1'b1;
               end
        45110: begin
                 chk("sm_mrst_x", int'(vs.pix_x), 0);
                 chk("sm_mrst_y", int'(vs.pix_y), 0);
                 chk("sm_mrst_pre_x", int'(vs.pre_x), 2);
                 chk("sm_mrst_fstart", int'(vs.frame_start), 0);
                 chk("sm_mrst_fcount", int'(vs.frame_count), 0);
                 rst_s = 1'b0;
               end
        45285: chk("sm_mrst_fcount_175", int'(vs.frame_count), 0);
        45286: begin
                 chk("sm_mrst_fcount_176", int'(vs.frame_count), 1);
                 chk("sm_mrst_fstart_176", int'(vs.frame_start), 1);
               end
        default: ;
      endcase
    end
    finish_run();
  end

endmodule
